gpr_snapshot_reader: RTL and testbench

//  Reads the 32-word GPR snapshot that the register-file dump path writes into BRAM
//  (byte addrs BASE_ADDR + 4*i), using the BRAM's second port.

---
 rtl/gpr_snapshot_reader_pkg.sv | 29 ++
 rtl/gpr_snap_fifo.sv | 60 ++++++
 rtl/gpr_snapshot_reader.sv | 135 +++++++++++++
 tb/tb_gpr_snapshot_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_snapshot_reader_pkg.sv
// ============================================================================
// Module   : gpr_snapshot_reader_pkg
// Purpose  : Shared GPR geometry, snapshot placement and reader types.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpr_snapshot_reader_pkg;

  localparam int          GPR_BIT        = 32;
  localparam int          GPR_ADR        = 5;
  localparam int          GPR_NUM        = 32;
  localparam logic [31:0] SNAP_BASE_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } snap_state_t;

  typedef struct packed {
    logic [GPR_ADR-1:0] idx;
    logic [GPR_BIT-1:0] data;
  } snap_word_t;

endpackage

`default_nettype wire

// File: rtl/gpr_snap_fifo.sv
// ============================================================================
// Module   : gpr_snap_fifo
// Purpose  : Small synchronous FIFO with occupancy count; head is read combinationally.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpr_snap_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop_ok  = i_pop & ~o_empty;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_push_ok = i_push & (~w_full | w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/gpr_snapshot_reader.sv
// ============================================================================
// Module   : gpr_snapshot_reader
// Purpose  : Reads the BRAM GPR snapshot via port B and streams it out by index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpr_snapshot_reader
  import gpr_snapshot_reader_pkg::*;
#(
  parameter int          WORD_NUM   = GPR_NUM,
  parameter logic [31:0] BASE_ADDR  = SNAP_BASE_ADDR,
  parameter int          RD_LAT     = 1,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_ram_en,
  output logic [3:0]          o_ram_we,
  output logic [31:0]         o_ram_addr,
  input  logic [31:0]         i_ram_rd_data,
  output logic [GPR_BIT-1:0]  o_m_data,
  output logic [GPR_ADR-1:0]  o_m_idx,
  output logic                o_m_last,
  output logic                o_m_valid,
  input  logic                i_m_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  snap_state_t        r_state;
  snap_state_t        w_state_nxt;
  logic [5:0]         r_rd_idx;
  logic [RD_LAT-1:0]  r_pipe_vld;
  logic [GPR_ADR-1:0] r_pipe_idx [RD_LAT];
  logic [CNT_W-1:0]   w_inflight;
  logic [CNT_W-1:0]   w_fifo_count;
  logic [OCC_W-1:0]   w_occ;
  logic               w_can_issue;
  logic               w_issue;
  logic               w_last_issue;
  logic               w_fifo_empty;
  logic               w_pop;
  logic               w_drained;
  snap_word_t         w_push_word;
  snap_word_t         w_head;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CNT_W'(r_pipe_vld[i]);
  end

  // Reads still in the BRAM pipe already own a FIFO slot; a same-cycle pop earns none.
  assign w_occ        = OCC_W'(w_fifo_count) + OCC_W'(w_inflight) + OCC_W'(1);
  assign w_can_issue  = (w_occ <= OCC_W'(FIFO_DEPTH));
  assign w_last_issue = (r_rd_idx == 6'(WORD_NUM - 1));
  assign w_pop        = ~w_fifo_empty & i_m_ready;
  assign w_drained    = (w_inflight == '0) &
                        ((w_fifo_count == '0) | ((w_fifo_count == CNT_W'(1)) & w_pop));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_READ;
      ST_READ: begin
        if (w_can_issue) begin
          w_issue = 1'b1;
          if (w_last_issue) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: if (w_drained) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || r_state == ST_DONE) r_rd_idx <= '0;
    else if (w_issue)              r_rd_idx <= r_rd_idx + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pipe_idx[i] <= '0;
    end else begin
      r_pipe_vld[0] <= w_issue;
      r_pipe_idx[0] <= r_rd_idx[GPR_ADR-1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
    end
  end

  assign w_push_word.idx  = r_pipe_idx[RD_LAT-1];
  assign w_push_word.data = i_ram_rd_data;

  gpr_snap_fifo #(
    .WIDTH ($bits(snap_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_pipe_vld[RD_LAT-1]),
    .i_data  (w_push_word),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE);
  assign o_ram_en   = w_issue;
  assign o_ram_we   = 4'b0000;
  assign o_ram_addr = BASE_ADDR + {24'd0, r_rd_idx, 2'b00};
  assign o_m_valid  = ~w_fifo_empty;
  assign o_m_data   = w_head.data;
  assign o_m_idx    = w_head.idx;
  assign o_m_last   = (w_head.idx == GPR_ADR'(WORD_NUM - 1)) & o_m_valid;

endmodule

`default_nettype wire

// File: tb/tb_gpr_snapshot_reader.sv
// ============================================================================
// Module   : tb_gpr_snapshot_reader
// Purpose  : Scoreboard bench for the GPR snapshot reader with a BRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpr_snapshot_reader;

  localparam int          NW        = 32;
  localparam int          TB_RD_LAT = 2;
  localparam int          TB_DEPTH  = 4;
  localparam logic [31:0] TB_BASE   = 32'h0000_0100;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_rd_data, m_data;
  logic [4:0]  m_idx;
  logic        m_last, m_valid, m_ready;

  logic [31:0] bram      [NW];
  logic [31:0] bram_pipe [TB_RD_LAT];

  exp_t        sb_q [$];
  exp_t        e;
  int          checks = 0, failures = 0;
  int          cyc = 0, issue_cnt = 0, popped = 0, hs_count = 0, done_count = 0;
  int          last_hs_cyc = -10, first_valid_cyc = -1, start_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [4:0]  prev_idx;

  gpr_snapshot_reader #(
    .WORD_NUM   (NW),
    .BASE_ADDR  (TB_BASE),
    .RD_LAT     (TB_RD_LAT),
    .FIFO_DEPTH (TB_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (start),
    .o_busy        (busy),
    .o_done        (done),
    .o_ram_en      (ram_en),
    .o_ram_we      (ram_we),
    .o_ram_addr    (ram_addr),
    .i_ram_rd_data (ram_rd_data),
    .o_m_data      (m_data),
    .o_m_idx       (m_idx),
    .o_m_last      (m_last),
    .o_m_valid     (m_valid),
    .i_m_ready     (m_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] bram_rd(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - TB_BASE;
    if (off[1:0] == 2'b00 && off < 32'(4 * NW)) return bram[off[6:2]];
    return 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) begin
    bram_pipe[0] <= ram_en ? bram_rd(ram_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < TB_RD_LAT; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign ram_rd_data = bram_pipe[TB_RD_LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: everything sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        chk("ram_we_zero", ram_we, 0);
        if (ram_en) begin
          chk("ram_addr", ram_addr, TB_BASE + 32'(4 * issue_cnt));
          chk("issue_room", 64'((issue_cnt - popped + 1) <= TB_DEPTH), 1);
          issue_cnt++;
        end
        if (prev_stall) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, prev_data);
          chk("stall_idx", m_idx, prev_idx);
        end
        if (!m_valid) chk("last_without_valid", m_last, 0);
        if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (m_valid && m_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual_idx=%0d actual_data=%0h required=none", m_idx, m_data);
          end else begin
            e = sb_q.pop_front();
            chk("m_data", m_data, e.data);
            chk("m_idx", m_idx, e.idx);
            chk("m_last", m_last, e.last);
          end
          popped++;
          hs_count++;
          if (m_last) last_hs_cyc = cyc;
        end
        if (done) begin
          chk("done_timing", cyc, last_hs_cyc + 1);
          done_count++;
        end
        prev_stall = m_valid & ~m_ready;
        prev_data  = m_data;
        prev_idx   = m_idx;
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_addr", ram_addr, TB_BASE);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_idx", m_idx, 0);
    chk("rst_m_last", m_last, 0);
  endtask

  task automatic push_expect();
    for (int i = 0; i < NW; i++)
      sb_q.push_back('{data: 32'hA5A5_0000 + 32'(i), idx: 5'(i), last: (i == NW - 1)});
  endtask

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 1) return 1'b1;
    if (mode == 2) return ($urandom_range(0, 9) < 3);
    return (k >= 50);
  endfunction

  // mode 0: ready held low for 50 cycles, 1: always ready, 2: ~30% random ready.
  task automatic run_snap(input bit extra_starts, input int mode);
    int done0;
    push_expect();
    issue_cnt = 0;
    popped = 0;
    first_valid_cyc = -1;
    done0 = done_count;
    start = 1'b1;
    m_ready = ready_for(mode, 0);
    start_cyc = cyc;
    @(posedge clk); #1;
    for (int k = 1; k < 3000 && done_count == done0; k++) begin
      start = extra_starts && (k == 3 || k == 20);
      if (mode == 0 && k == 50) chk("stalled_issue_count", issue_cnt, TB_DEPTH);
      m_ready = ready_for(mode, k);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_seen", done_count - done0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("single_done", done_count - done0, 1);
    chk("words_left", sb_q.size(), 0);
    chk("issues_total", issue_cnt, NW);
    chk("first_valid_latency", first_valid_cyc - start_cyc, TB_RD_LAT + 2);
    chk("idle_busy", busy, 0);
    sb_q.delete();
  endtask

  initial begin
    for (int i = 0; i < NW; i++) bram[i] = 32'hA5A5_0000 + 32'(i);
    rst = 1'b1;
    start = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;

    run_snap(1'b0, 1);
    run_snap(1'b0, 2);
    run_snap(1'b0, 2);
    run_snap(1'b0, 0);
    run_snap(1'b1, 1);

    // Reset one cycle after the word-10 handshake, mid-stream.
    push_expect();
    issue_cnt = 0;
    popped = 0;
    hs_count = 0;
    start = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 500 && hs_count < 11; k++) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_words", 64'(hs_count >= 11), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    issue_cnt = 0;
    popped = 0;
    last_hs_cyc = -10;
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    run_snap(1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
